// File: rtl/pw_line_pkg.sv
// Shared definitions for the pulse-width serial line: state encoding, line
// levels, default bit timings and the duration counter width. Used by the
// transmitter RTL and by receiver-side benches.
package pw_line_pkg;

  // Duration counter width; every timing parameter must fit in 1..63.
  localparam int CNT_W = 6;

  // Default timings in clocks. A 1 is a short space, a 0 a long space,
  // and every bit is followed by the same mark gap.
  localparam int DEF_ONE_LEN  = 4;
  localparam int DEF_ZERO_LEN = 13;
  localparam int DEF_GAP_LEN  = 20;

  // Line levels: mark is the idle level.
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACK   = 2'd1;
  localparam state_t S_SPACE = 2'd2;
  localparam state_t S_MARK  = 2'd3;

  // Counter preload for a space: the counter runs down to zero inclusive,
  // so a space of N clocks loads N-1.
  function automatic logic [CNT_W-1:0] space_load(input logic bit_val,
                                                  input int   one_len,
                                                  input int   zero_len);
    return bit_val ? CNT_W'(one_len - 1) : CNT_W'(zero_len - 1);
  endfunction

endpackage

// File: rtl/pw_bit_serializer.sv
// Pulse-width bit serializer. Holds the byte being sent, the bit index and
// the duration counter, and drives the line. A byte is latched with `load`
// and sent LSB first after `start`; `done` is high on the last clock of the
// final mark gap.
module pw_bit_serializer
  import pw_line_pkg::*;
#(
  parameter int ONE_LEN  = DEF_ONE_LEN,
  parameter int ZERO_LEN = DEF_ZERO_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       start,
  output logic       txd,
  output logic       done,
  output state_t     phase
);

  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] cnt;

  // Space/mark sequencer: each bit is one space followed by one mark gap.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      phase   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      txd     <= MARK;
    end else begin
      if (load) begin
        shift <= data;
      end
      case (phase)
        S_IDLE: begin
          if (start) begin
            txd     <= SPACE;
            bit_idx <= '0;
            cnt     <= space_load(shift[0], ONE_LEN, ZERO_LEN);
            phase   <= S_SPACE;
          end
        end
        S_SPACE: begin
          if (cnt == '0) begin
            txd   <= MARK;
            cnt   <= CNT_W'(GAP_LEN - 1);
            phase <= S_MARK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_MARK: begin
          if (cnt == '0) begin
            if (bit_idx != 3'd7) begin
              // Next bit comes from shift[1], which becomes shift[0].
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= SPACE;
              cnt     <= space_load(shift[1], ONE_LEN, ZERO_LEN);
              phase   <= S_SPACE;
            end else begin
              phase <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          phase <= S_IDLE;
        end
      endcase
    end
  end

  assign done = (phase == S_MARK) && (cnt == '0) && (bit_idx == 3'd7);

endmodule

// File: rtl/pw_tx_arbiter.sv
// Transmit arbiter for the pulse-width line. Two producers share the line;
// one is granted, its byte latched, and the byte is serialized LSB first.
// Build option PW_TX_FIXED_PRIO_EN: requester 0 always wins a tie instead
// of round-robin. Ports and timing are the same in both builds.
//
// Handshake (4-phase, per requester): the producer raises req with data
// stable; the arbiter answers ack=1 on the grant edge; the producer drops
// req; the edge that samples req=0 clears ack and puts the first space on
// the line. A req raised again while its own byte is on the wire simply
// waits for the next arbitration in S_IDLE.
module pw_tx_arbiter
  import pw_line_pkg::*;
#(
  parameter int ONE_LEN  = DEF_ONE_LEN,
  parameter int ZERO_LEN = DEF_ZERO_LEN,
  parameter int GAP_LEN  = DEF_GAP_LEN
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       txd,
  output logic       busy,
  output state_t     state
);

  // ctl holds S_IDLE, S_ACK, or S_SPACE meaning "serializer running".
  state_t     ctl;
  logic       gnt;
  logic       pick;
  logic       req_g;
  logic       load;
  logic       start;
  logic       done;
  logic [7:0] load_data;
  state_t     phase;

`ifdef PW_TX_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    pick = ~req0;
  end
`else
  logic last;

  // Round-robin: a tie goes to the requester not served last.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end
`endif

  assign req_g     = gnt ? req1 : req0;
  assign load      = (ctl == S_IDLE) && (req0 || req1);
  assign load_data = pick ? data1 : data0;
  assign start     = (ctl == S_ACK) && !req_g;

  // Arbitration, acknowledge and busy sequencing.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ctl  <= S_IDLE;
      gnt  <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= 1'b0;
`ifndef PW_TX_FIXED_PRIO_EN
      last <= 1'b1;
`endif
    end else begin
      case (ctl)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt  <= pick;
            ack0 <= ~pick;
            ack1 <= pick;
            busy <= 1'b1;
`ifndef PW_TX_FIXED_PRIO_EN
            last <= pick;
`endif
            ctl  <= S_ACK;
          end
        end
        S_ACK: begin
          if (!req_g) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            ctl  <= S_SPACE;
          end
        end
        S_SPACE: begin
          if (done) begin
            busy <= 1'b0;
            ctl  <= S_IDLE;
          end
        end
        default: begin
          ctl <= S_IDLE;
        end
      endcase
    end
  end

  pw_bit_serializer #(
    .ONE_LEN (ONE_LEN),
    .ZERO_LEN(ZERO_LEN),
    .GAP_LEN (GAP_LEN)
  ) u_ser (
    .clock (clock),
    .reset_(reset_),
    .load  (load),
    .data  (load_data),
    .start (start),
    .txd   (txd),
    .done  (done),
    .phase (phase)
  );

  // Visible state: the serializer's space/mark phase while a byte is sent.
  assign state = (ctl == S_SPACE) ? phase : ctl;

endmodule

// File: tb/tb_pw_tx_arbiter.sv
// Directed bench for pw_tx_arbiter: single request timing, tie handling,
// continuous contention, async reset mid-byte and a long handshake. A line
// monitor decodes txd back into bytes for the scoreboard.
`timescale 1ns/1ps
module tb_pw_tx_arbiter;
  import pw_line_pkg::*;

  localparam int ONE_LEN  = 4;
  localparam int ZERO_LEN = 13;
  localparam int GAP_LEN  = 20;

  logic       clock  = 1'b0;
  logic       reset_ = 1'b0;
  logic       req0   = 1'b0;
  logic       req1   = 1'b0;
  logic [7:0] data0  = 8'h00;
  logic [7:0] data1  = 8'h00;
  logic       ack0;
  logic       ack1;
  logic       txd;
  logic       busy;
  state_t     state;

  int n_checks = 0;
  int n_fail   = 0;
  int last_idle = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [0:0] exp_gnt_q[$];
  logic [0:0] gnt_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  pw_tx_arbiter #(
    .ONE_LEN (ONE_LEN),
    .ZERO_LEN(ZERO_LEN),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .req0  (req0),
    .data0 (data0),
    .ack0  (ack0),
    .req1  (req1),
    .data1 (data1),
    .ack1  (ack1),
    .txd   (txd),
    .busy  (busy),
    .state (state)
  );

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- line monitor (decodes txd) ----------------
  initial begin : line_monitor
    int         sp_len;
    int         mk_len;
    int         bit_n;
    logic [7:0] sh;
    sp_len = 0;
    mk_len = 0;
    bit_n  = 0;
    sh     = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        sp_len = 0;
        mk_len = 0;
        bit_n  = 0;
        sh     = 8'h00;
      end else if (txd == SPACE) begin
        if (sp_len == 0 && bit_n > 0) check_eq("gap_len", 32'(mk_len), 32'(GAP_LEN));
        mk_len = 0;
        sp_len++;
      end else begin
        if (sp_len > 0) begin
          if (sp_len != ONE_LEN) check_eq("zero_space_len", 32'(sp_len), 32'(ZERO_LEN));
          sh = {(sp_len == ONE_LEN), sh[7:1]};
          bit_n++;
          if (bit_n == 8) begin
            rx_q.push_back(sh);
            bit_n = 0;
          end
          sp_len = 0;
        end
        mk_len++;
      end
    end
  end

  // Grant order and idle-gap tracking.
  initial begin : ctl_monitor
    logic a0p;
    logic a1p;
    int   idle_run;
    a0p = 1'b0;
    a1p = 1'b0;
    idle_run = 0;
    forever begin
      @(negedge clock);
      if (ack0 && !a0p) gnt_q.push_back(1'b0);
      if (ack1 && !a1p) gnt_q.push_back(1'b1);
      a0p = ack0;
      a1p = ack1;
      if (!busy) begin
        idle_run++;
      end else begin
        if (idle_run > 0) last_idle = idle_run;
        idle_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit r, input logic lvl, input string tag);
    int n;
    n = 0;
    while (((r ? ack1 : ack0) !== lvl) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) check_eq(tag, 32'(r ? ack1 : ack0), 32'(lvl));
  endtask

  task automatic handshake(input bit r, input logic [7:0] d, input int hold);
    @(negedge clock);
    if (r) begin
      data1 = d;
      req1  = 1'b1;
    end else begin
      data0 = d;
      req0  = 1'b1;
    end
    wait_ack(r, 1'b1, "ack_rise_timeout");
    repeat (hold) @(negedge clock);
    if (r) req1 = 1'b0;
    else   req0 = 1'b0;
    wait_ack(r, 1'b0, "ack_fall_timeout");
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) check_eq(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b0;
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    rx_q.delete();
    gnt_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain(input string tag);
    logic [7:0] e;
    logic [0:0] g;
    check_eq({tag, "_byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    check_eq({tag, "_grant_count"}, 32'(gnt_q.size()), 32'(exp_gnt_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) check_eq({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(e));
    end
    while (exp_gnt_q.size() > 0) begin
      g = exp_gnt_q.pop_front();
      if (gnt_q.size() > 0) check_eq({tag, "_grant"}, 32'(gnt_q.pop_front()), 32'(g));
    end
    rx_q.delete();
    gnt_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    int bad;

    // Reset state.
    repeat (3) @(negedge clock);
    check_eq("rst_txd",   32'(txd),   32'd1);
    check_eq("rst_ack0",  32'(ack0),  32'd0);
    check_eq("rst_ack1",  32'(ack1),  32'd0);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    reset_ = 1'b1;

    // T1: single request 0xA5; wire time 4*4 + 4*13 + 8*20 = 228.
    @(negedge clock);
    data0 = 8'hA5;
    req0  = 1'b1;
    exp_q.push_back(8'hA5);
    exp_gnt_q.push_back(1'b0);
    @(negedge clock);
    check_eq("t1_ack0_rise", 32'(ack0),  32'd1);
    check_eq("t1_busy_rise", 32'(busy),  32'd1);
    check_eq("t1_txd_hold",  32'(txd),   32'd1);
    check_eq("t1_state_ack", 32'(state), 32'(S_ACK));
    req0 = 1'b0;
    @(negedge clock);
    check_eq("t1_txd_fall",   32'(txd),   32'd0);
    check_eq("t1_ack0_fall",  32'(ack0),  32'd0);
    check_eq("t1_state_space", 32'(state), 32'(S_SPACE));
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clock);
    end
    check_eq("t1_wire_time", 32'(n), 32'd228);
    repeat (2) @(negedge clock);
    check_eq("t1_state_idle", 32'(state), 32'(S_IDLE));
    drain("t1");

    // T2: simultaneous requests after reset; 0 first, then 1 after one idle clock.
    do_reset();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    fork
      handshake(1'b0, 8'h01, 0);
      handshake(1'b1, 8'h80, 0);
    join
    wait_idle("t2_idle_timeout");
    check_eq("t2_idle_between", 32'(last_idle), 32'd1);
    drain("t2");

    // T3: both requesters keep requesting for two bytes each.
`ifdef PW_TX_FIXED_PRIO_EN
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h44);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    exp_gnt_q.push_back(1'b1);
`else
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
`endif
    fork
      begin
        handshake(1'b0, 8'h11, 0);
        handshake(1'b0, 8'h33, 0);
      end
      begin
        handshake(1'b1, 8'h22, 0);
        handshake(1'b1, 8'h44, 0);
      end
    join
    wait_idle("t3_idle_timeout");
    drain("t3");

    // T4: async reset in the middle of bit 3's space (byte 0x00: 33 clocks/bit).
    handshake(1'b0, 8'h00, 0);
    repeat (104) @(negedge clock);
    check_eq("t4_in_space", 32'(txd), 32'd0);
    #2;
    reset_ = 1'b0;
    #1;
    check_eq("t4_rst_txd",   32'(txd),   32'd1);
    check_eq("t4_rst_ack0",  32'(ack0),  32'd0);
    check_eq("t4_rst_ack1",  32'(ack1),  32'd0);
    check_eq("t4_rst_busy",  32'(busy),  32'd0);
    check_eq("t4_rst_state", 32'(state), 32'(S_IDLE));
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    check_eq("t4_no_partial", 32'(rx_q.size()), 32'd0);
    gnt_q.delete();
    exp_q.push_back(8'h3C);
    exp_gnt_q.push_back(1'b1);
    handshake(1'b1, 8'h3C, 0);
    wait_idle("t4_idle_timeout");
    drain("t4");

    // T5: requester 0 holds req 50 clocks after ack; requester 1 waits.
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    @(negedge clock);
    data0 = 8'h5A;
    req0  = 1'b1;
    wait_ack(1'b0, 1'b1, "t5_ack0_timeout");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (i == 10) begin
        data1 = 8'hC3;
        req1  = 1'b1;
      end
      if (txd !== 1'b1 || state !== S_ACK || ack1 !== 1'b0 || ack0 !== 1'b1) bad++;
    end
    check_eq("t5_hold_in_ack", 32'(bad), 32'd0);
    req0 = 1'b0;
    wait_ack(1'b1, 1'b1, "t5_ack1_timeout");
    check_eq("t5_byte0_done_before_ack1", 32'(rx_q.size()), 32'd1);
    req1 = 1'b0;
    wait_ack(1'b1, 1'b0, "t5_ack1_fall_timeout");
    wait_idle("t5_idle_timeout");
    drain("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
